// File: rtl/hci_core_sink_v2_pkg.sv
// Shared types for the HCI v2 write streamer and its address generator.
// No logic: state encoding and a width helper only.
// No backpressure: no logic here.
package hci_core_sink_v2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DRAIN   = 2'd2
    } hci_sink_v2_state_e;

    function automatic int unsigned byte_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/hci_core_sink_addrgen_2d.sv
// 2D address generator: base + i*d0_stride + j*d1_stride, one address per accepted push.
// Latency: first address valid the cycle after start.
// Backpressure: holds addr_dat/addr_last while addr_rdy is low; enable low freezes it.
module hci_core_sink_addrgen_2d #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TRANS_CNT  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [TRANS_CNT-1:0]  tot_len,
    input  logic [TRANS_CNT-1:0]  d0_len,
    input  logic [ADDR_WIDTH-1:0] d0_stride,
    input  logic [ADDR_WIDTH-1:0] d1_stride,
    output logic                  addr_vld,
    input  logic                  addr_rdy,
    output logic [ADDR_WIDTH-1:0] addr_dat,
    output logic                  addr_last
);

    logic                  active;
    logic [TRANS_CNT-1:0]  idx;
    logic [TRANS_CNT-1:0]  col;
    logic [ADDR_WIDTH-1:0] row_off;
    logic [ADDR_WIDTH-1:0] col_off;
    logic [TRANS_CNT-1:0]  d0_eff;
    logic                  row_end;
    logic                  fire;

    // A zero row length behaves as a one-word row so the walk always advances.
    assign d0_eff    = (d0_len == '0) ? TRANS_CNT'(1) : d0_len;
    assign row_end   = (col == d0_eff - TRANS_CNT'(1));
    assign addr_last = (idx == tot_len - TRANS_CNT'(1));
    assign addr_vld  = active;
    assign addr_dat  = base + row_off + col_off;
    assign fire      = active & addr_rdy & enable;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active  <= 1'b0;
            idx     <= '0;
            col     <= '0;
            row_off <= '0;
            col_off <= '0;
        end else if (clear) begin
            active  <= 1'b0;
            idx     <= '0;
            col     <= '0;
            row_off <= '0;
            col_off <= '0;
        end else if (enable) begin
            if (start) begin
                active  <= 1'b1;
                idx     <= '0;
                col     <= '0;
                row_off <= '0;
                col_off <= '0;
            end else if (fire) begin
                if (addr_last) begin
                    active <= 1'b0;
                end else begin
                    idx <= idx + TRANS_CNT'(1);
                    if (row_end) begin
                        col     <= '0;
                        col_off <= '0;
                        row_off <= row_off + d1_stride;
                    end else begin
                        col     <= col + TRANS_CNT'(1);
                        col_off <= col_off + d0_stride;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_fifo.sv
// Generic synchronous FIFO, power-of-two depth, registered storage.
// Latency: one cycle from push to pop_vld.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module hwpe_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear,
    input  logic                  push_vld,
    output logic                  push_rdy,
    input  logic [DATA_WIDTH-1:0] push_dat,
    output logic                  pop_vld,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] pop_dat
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           fill;
    logic                  push_fire;
    logic                  pop_fire;

    assign pop_vld   = (fill != '0);
    assign push_rdy  = (fill != FULL_CNT) | pop_rdy;
    assign push_fire = push_vld & push_rdy;
    assign pop_fire  = pop_vld & pop_rdy;
    assign pop_dat   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_fire, pop_fire})
                2'b10:   fill <= fill + (PW + 1)'(1);
                2'b01:   fill <= fill - (PW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_fire) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/hci_core_sink_v2.sv
// Stream-to-TCDM write streamer with 2D addressing and sub-word byte realignment.
// Latency: first request two cycles after start (addrgen register + address FIFO).
// Backpressure: stream beat accepted only on req & gnt; address FIFO stalls the addrgen.
module hci_core_sink_v2
    import hci_core_sink_v2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ADDR_FIFO_DEPTH = 2,
    parameter int unsigned TRANS_CNT       = 16,
    parameter bit          MISALIGNED      = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [TRANS_CNT-1:0]    tot_len_i,
    input  logic [TRANS_CNT-1:0]    d0_len_i,
    input  logic [ADDR_WIDTH-1:0]   d0_stride_i,
    input  logic [ADDR_WIDTH-1:0]   d1_stride_i,
    input  logic                    stream_valid_i,
    output logic                    stream_ready_o,
    input  logic [DATA_WIDTH-1:0]   stream_data_i,
    input  logic [DATA_WIDTH/8-1:0] stream_strb_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    output logic                    ready_start_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [TRANS_CNT-1:0]    cnt_o
);

    localparam int unsigned OFF_W = byte_off_bits(DATA_WIDTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        logic [TRANS_CNT-1:0]  tot_len;
        logic [TRANS_CNT-1:0]  d0_len;
        logic [ADDR_WIDTH-1:0] d0_stride;
        logic [ADDR_WIDTH-1:0] d1_stride;
    } hci_sink_v2_ctrl_t;

    hci_sink_v2_state_e    state;
    hci_sink_v2_ctrl_t     ctrl_q;
    hci_sink_v2_ctrl_t     ctrl_in;
    logic [TRANS_CNT-1:0]  cnt;
    logic                  done_q;

    logic                  busy;
    logic                  start_acc;
    logic                  req;
    logic                  hs;
    logic                  ag_vld;
    logic                  ag_rdy;
    logic                  ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  fifo_vld;
    logic [ADDR_WIDTH-1:0] fifo_addr;
    logic [OFF_W-1:0]      offset;

    always_comb begin
        ctrl_in           = '0;
        ctrl_in.base      = base_addr_i;
        ctrl_in.tot_len   = tot_len_i;
        ctrl_in.d0_len    = d0_len_i;
        ctrl_in.d0_stride = d0_stride_i;
        ctrl_in.d1_stride = d1_stride_i;
    end

    assign busy      = (state != IDLE);
    assign start_acc = (state == IDLE) & start_i & enable_i & ~clear_i;

    // Request depends only on registered FIFO state and stream/enable inputs, never on gnt.
    assign req = busy & enable_i & stream_valid_i & fifo_vld;
    assign hs  = req & tcdm_gnt_i;

    assign offset = MISALIGNED ? fifo_addr[OFF_W-1:0] : '0;

    assign tcdm_req_o     = req;
    assign tcdm_wen_o     = 1'b0;
    assign tcdm_add_o     = req ? {fifo_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign tcdm_be_o      = req ? (stream_strb_i << offset) : '0;
    assign tcdm_data_o    = req ? (stream_data_i << {offset, 3'b000}) : '0;
    assign stream_ready_o = hs;

    assign ready_start_o = ~busy;
    assign busy_o        = busy;
    assign done_o        = done_q;
    assign cnt_o         = cnt;

    hci_core_sink_addrgen_2d #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TRANS_CNT  (TRANS_CNT)
    ) i_addrgen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear      (clear_i),
        .enable     (enable_i),
        .start      (start_acc & (tot_len_i != '0)),
        .base       (ctrl_q.base),
        .tot_len    (ctrl_q.tot_len),
        .d0_len     (ctrl_q.d0_len),
        .d0_stride  (ctrl_q.d0_stride),
        .d1_stride  (ctrl_q.d1_stride),
        .addr_vld   (ag_vld),
        .addr_rdy   (ag_rdy),
        .addr_dat   (ag_addr),
        .addr_last  (ag_last)
    );

    hwpe_stream_fifo #(
        .DATA_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (ADDR_FIFO_DEPTH)
    ) i_addr_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear      (clear_i),
        .push_vld   (ag_vld & enable_i),
        .push_rdy   (ag_rdy),
        .push_dat   (ag_addr),
        .pop_vld    (fifo_vld),
        .pop_rdy    (hs),
        .pop_dat    (fifo_addr)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            ctrl_q <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (clear_i) begin
            state  <= IDLE;
            ctrl_q <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (enable_i) begin
                if (hs) cnt <= cnt + TRANS_CNT'(1);
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            ctrl_q <= ctrl_in;
                            cnt    <= '0;
                            state  <= (tot_len_i == '0) ? DRAIN : WORKING;
                        end
                    end
                    WORKING: begin
                        if (ag_vld & ag_rdy & ag_last) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (cnt == ctrl_q.tot_len) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
